// File: rtl/ring_phase_monitor.sv
// Checks a one-hot ring counter: each sample must be a single rotation of the previous one.
// Reports phase index and lock status, counts revolutions, and latches a sticky fault on illegal steps.
module ring_phase_monitor #(
   parameter int WIDTH    = 4,
   parameter int DIR      = 0,
   parameter int LOCK_CNT = 2,
   parameter int REV_W    = 8,
   parameter int ERR_W    = 4
) (
   input  logic                       Clock,
   input  logic                       Reset_n,
   input  logic [WIDTH-1:0]           Count_in,
   input  logic                       Clear,
   output logic [$clog2(WIDTH)-1:0]   Phase_idx,
   output logic                       Phase_valid,
   output logic                       Rev_tick,
   output logic [REV_W-1:0]           Rev_count,
   output logic                       Fault,
   output logic [ERR_W-1:0]           Err_count
);

   localparam int IDX_W = $clog2(WIDTH);
   localparam int CNT_W = $clog2(LOCK_CNT + 1);

   typedef enum logic [1:0] {
      SYNC   = 2'd0,
      LOCKED = 2'd1,
      FAULT  = 2'd2
   } state_t;

   state_t             state, state_n;
   logic [WIDTH-1:0]   prev_q;
   logic               prev_v;
   logic [CNT_W-1:0]   good_cnt, good_cnt_n, cnt_inc;
   logic               fault_n;
   logic [ERR_W-1:0]   err_n;
   logic [REV_W-1:0]   rev_n;
   logic               good_step, bad_step, rev_evt;

   function automatic logic is_onehot(input logic [WIDTH-1:0] v);
      int n;
      n = 0;
      for (int i = 0; i < WIDTH; i++) n += int'(v[i]);
      return (n == 1);
   endfunction

   function automatic logic [WIDTH-1:0] rotate(input logic [WIDTH-1:0] v);
      if (DIR == 0) return {v[WIDTH-2:0], v[WIDTH-1]};
      else          return {v[0], v[WIDTH-1:1]};
   endfunction

   // Non-one-hot samples report index 0 rather than a partial encoding.
   function automatic logic [IDX_W-1:0] onehot_idx(input logic [WIDTH-1:0] v);
      logic [IDX_W-1:0] idx;
      idx = '0;
      if (is_onehot(v)) begin
         for (int i = 0; i < WIDTH; i++) begin
            if (v[i]) idx = IDX_W'(i);
         end
      end
      return idx;
   endfunction

   function automatic logic [ERR_W-1:0] sat_inc(input logic [ERR_W-1:0] e);
      return (e == {ERR_W{1'b1}}) ? e : e + 1'b1;
   endfunction

   assign good_step = prev_v && is_onehot(prev_q) && (Count_in == rotate(prev_q));
   assign bad_step  = prev_v && !good_step;
   assign rev_evt   = (state == LOCKED) && good_step && Count_in[0];
   assign cnt_inc   = good_cnt + 1'b1;

   always_comb begin
      state_n    = state;
      good_cnt_n = good_cnt;
      fault_n    = Fault;
      err_n      = Err_count;
      rev_n      = Rev_count;

      case (state)
         SYNC: begin
            if (good_step) begin
               if (cnt_inc == CNT_W'(LOCK_CNT)) begin
                  state_n    = LOCKED;
                  good_cnt_n = '0;
               end else begin
                  good_cnt_n = cnt_inc;
               end
            end else if (bad_step) begin
               good_cnt_n = '0;
            end
         end
         LOCKED: begin
            if (bad_step && !Clear) begin
               state_n = FAULT;
               fault_n = 1'b1;
               err_n   = sat_inc(Err_count);
            end
         end
         FAULT:   state_n = FAULT;
         default: state_n = SYNC;
      endcase

      if (rev_evt) rev_n = Rev_count + 1'b1;

      // Clear wins over a same-edge fault or revolution increment; Rev_tick still fires.
      if (Clear) begin
         fault_n    = 1'b0;
         err_n      = '0;
         rev_n      = '0;
         good_cnt_n = '0;
         if (state == FAULT) state_n = SYNC;
      end
   end

   always_ff @(posedge Clock or negedge Reset_n) begin
      if (!Reset_n) begin
         state       <= SYNC;
         good_cnt    <= '0;
         prev_q      <= '0;
         prev_v      <= 1'b0;
         Phase_idx   <= '0;
         Phase_valid <= 1'b0;
         Rev_tick    <= 1'b0;
         Rev_count   <= '0;
         Fault       <= 1'b0;
         Err_count   <= '0;
      end else begin
         state       <= state_n;
         good_cnt    <= good_cnt_n;
         prev_q      <= Count_in;
         prev_v      <= 1'b1;
         Phase_idx   <= onehot_idx(Count_in);
         Phase_valid <= (state_n == LOCKED);
         Rev_tick    <= rev_evt;
         Rev_count   <= rev_n;
         Fault       <= fault_n;
         Err_count   <= err_n;
      end
   end

endmodule

// File: tb/tb_ring_phase_monitor.sv
// Directed bench for ring_phase_monitor; a second instance with REV_W=2 shares the stimulus.
module tb_ring_phase_monitor;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic [3:0] count_in = 4'b0000;
   logic       clear = 1'b0;

   logic [1:0] phase_idx,   w2_phase_idx;
   logic       phase_valid, w2_phase_valid;
   logic       rev_tick,    w2_rev_tick;
   logic [7:0] rev_count;
   logic [1:0] w2_rev_count;
   logic       fault,       w2_fault;
   logic [3:0] err_count,   w2_err_count;

   int n_chk = 0;
   int n_err = 0;
   int ticks = 0;

   always #5 clk = ~clk;

   ring_phase_monitor dut (
      .Clock(clk), .Reset_n(rst_n), .Count_in(count_in), .Clear(clear),
      .Phase_idx(phase_idx), .Phase_valid(phase_valid), .Rev_tick(rev_tick),
      .Rev_count(rev_count), .Fault(fault), .Err_count(err_count)
   );

   ring_phase_monitor #(.REV_W(2)) dut_w2 (
      .Clock(clk), .Reset_n(rst_n), .Count_in(count_in), .Clear(clear),
      .Phase_idx(w2_phase_idx), .Phase_valid(w2_phase_valid), .Rev_tick(w2_rev_tick),
      .Rev_count(w2_rev_count), .Fault(w2_fault), .Err_count(w2_err_count)
   );

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   task automatic drive(input logic [3:0] v, input logic c);
      count_in = v;
      clear    = c;
      @(posedge clk);
      #1;
      clear    = 1'b0;
   endtask

   initial begin
      // reset state
      repeat (2) @(posedge clk);
      #1;
      chk("rst_valid", phase_valid, 0);
      chk("rst_idx",   phase_idx,   0);
      chk("rst_fault", fault,       0);
      chk("rst_err",   err_count,   0);
      chk("rst_rev",   rev_count,   0);
      chk("rst_tick",  rev_tick,    0);

      // lock from reset
      @(negedge clk);
      rst_n = 1'b1;
      drive(4'b0001, 0);
      chk("lock_e1_valid", phase_valid, 0);
      drive(4'b0010, 0);
      chk("lock_e2_valid", phase_valid, 0);
      drive(4'b0100, 0);
      chk("lock_e3_valid", phase_valid, 1);
      chk("lock_e3_idx",   phase_idx,   2);
      drive(4'b1000, 0);
      chk("lock_e4_idx",   phase_idx,   3);
      chk("lock_e4_valid", phase_valid, 1);
      chk("lock_e4_fault", fault,       0);

      // ten revolutions, with the 2-bit instance wrapping 1,2,3,0,1,...
      for (int r = 1; r <= 10; r++) begin
         drive(4'b0001, 0);
         if (rev_tick) ticks++;
         chk("rev_tick_hi", rev_tick,     1);
         chk("rev_idx0",    phase_idx,    0);
         chk("rev_count",   rev_count,    r);
         chk("rev_wrap",    w2_rev_count, r % 4);
         drive(4'b0010, 0);
         if (rev_tick) ticks++;
         chk("rev_tick_lo", rev_tick,     0);
         drive(4'b0100, 0);
         if (rev_tick) ticks++;
         drive(4'b1000, 0);
         if (rev_tick) ticks++;
      end
      chk("rev_ticks_total", ticks,     10);
      chk("rev_count_final", rev_count, 10);

      // illegal step 0010 -> 1000
      drive(4'b0001, 0);
      drive(4'b0010, 0);
      chk("pre_bad_valid", phase_valid, 1);
      drive(4'b1000, 0);
      chk("bad_fault", fault,       1);
      chk("bad_valid", phase_valid, 0);
      chk("bad_err",   err_count,   1);
      chk("bad_idx",   phase_idx,   3);
      drive(4'b0001, 0);
      chk("fault_no_tick", rev_tick, 0);
      drive(4'b0010, 0);
      drive(4'b0100, 0);
      chk("fault_hold",       fault,       1);
      chk("fault_hold_valid", phase_valid, 0);
      chk("fault_hold_rev",   rev_count,   11);

      // clear from FAULT, then relock on two clean steps
      drive(4'b0000, 1);
      chk("clr_fault", fault,       0);
      chk("clr_err",   err_count,   0);
      chk("clr_rev",   rev_count,   0);
      chk("clr_valid", phase_valid, 0);
      drive(4'b0001, 0);
      chk("relock_s1", phase_valid, 0);
      drive(4'b0010, 0);
      chk("relock_s2", phase_valid, 0);
      drive(4'b0100, 0);
      chk("relock_s3", phase_valid, 1);
      chk("relock_idx", phase_idx,  2);

      // clear on the same edge as a bad step
      drive(4'b0001, 1);
      chk("clrbad_valid", phase_valid, 1);
      chk("clrbad_fault", fault,       0);
      chk("clrbad_err",   err_count,   0);
      chk("clrbad_tick",  rev_tick,    0);
      drive(4'b0010, 0);
      chk("clrbad_cont",  phase_valid, 1);

      // clear on the same edge as a revolution
      drive(4'b0100, 0);
      drive(4'b1000, 0);
      drive(4'b0001, 0);
      chk("pre_clrrev_count", rev_count, 1);
      drive(4'b0010, 0);
      drive(4'b0100, 0);
      drive(4'b1000, 0);
      drive(4'b0001, 1);
      chk("clrrev_tick",  rev_tick,  1);
      chk("clrrev_count", rev_count, 0);

      // async reset between edges while locked
      drive(4'b0010, 0);
      drive(4'b0100, 0);
      drive(4'b1000, 0);
      drive(4'b0001, 0);
      drive(4'b0010, 0);
      chk("pre_arst_valid", phase_valid, 1);
      chk("pre_arst_idx",   phase_idx,   1);
      chk("pre_arst_rev",   rev_count,   1);
      #3;
      rst_n    = 1'b0;
      count_in = 4'b0000;
      #1;
      chk("arst_valid", phase_valid, 0);
      chk("arst_idx",   phase_idx,   0);
      chk("arst_rev",   rev_count,   0);
      chk("arst_fault", fault,       0);
      chk("arst_tick",  rev_tick,    0);

      // multi-hot sample in SYNC delays lock
      @(negedge clk);
      rst_n = 1'b1;
      drive(4'b0011, 0);
      chk("mh_idx", phase_idx, 0);
      drive(4'b0100, 0);
      chk("mh_s1_valid", phase_valid, 0);
      drive(4'b1000, 0);
      chk("mh_s2_valid", phase_valid, 0);
      drive(4'b0001, 0);
      chk("mh_lock_valid", phase_valid, 1);
      chk("mh_lock_idx",   phase_idx,   0);
      chk("mh_lock_tick",  rev_tick,    0);
      chk("mh_lock_fault", fault,       0);

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule

// File: doc/ring_phase_monitor.md
# ring_phase_monitor

Downstream checker for the 4-bit one-hot ring counter. It samples the ring counter's `Count_out` every clock and verifies that each step is one-hot and a single rotation of the previous step. It reports the current phase as a binary index, counts completed revolutions, and raises a sticky fault on any illegal step. It sits between the ring counter and the phase-driven logic, which uses `Phase_valid` to gate itself.

## Interface
- `WIDTH`, default 4: ring width; `Count_in` is one-hot of this width.
- `DIR`, default 0: expected rotation. 0 = toward MSB (0001→0010→0100→1000→0001); 1 = toward LSB.
- `LOCK_CNT`, default 2: number of consecutive good steps required to lock (≥1).
- `REV_W`, default 8: revolution counter width.
- `ERR_W`, default 4: error counter width.

Ports:
- `Clock`, input, 1: rising-edge clock, same clock as the ring counter.
- `Reset_n`, input, 1: asynchronous, active-low reset.
- `Count_in`, input, WIDTH: ring counter output.
- `Clear`, input, 1: synchronous. Clears fault and both counters.
- `Phase_idx`, output, $clog2(WIDTH): binary index of the set bit in the last sample. 0 if the sample is not one-hot.
- `Phase_valid`, output, 1: high only in LOCKED.
- `Rev_tick`, output, 1: one-cycle pulse per completed revolution.
- `Rev_count`, output, REV_W: revolutions counted while locked. Wraps.
- `Fault`, output, 1: sticky illegal-step flag.
- `Err_count`, output, ERR_W: number of faults. Saturates.

## Operation
- Every edge registers `prev_q <= Count_in` and sets `prev_v <= 1`.
- Good step: `prev_v` is 1, `prev_q` is one-hot, and `Count_in` equals `rotate(prev_q, DIR)`.
- Bad step: any sample with `prev_v` = 1 that is not a good step.
- FSM state SYNC (reset state):
  - A good step increments `good_cnt`.
  - A bad step clears `good_cnt` to 0.
  - When `good_cnt` reaches LOCK_CNT, go to LOCKED and clear `good_cnt`.
- FSM state LOCKED:
  - A good step stays in LOCKED.
  - A bad step goes to FAULT, sets `Fault` to 1 and increments `Err_count`, saturating at 2^ERR_W−1.
- FSM state FAULT: holds regardless of `Count_in` until `Clear`.
- Revolution: a good step in LOCKED whose `Count_in` is phase 0 (bit 0 set) increments `Rev_count` modulo 2^REV_W and pulses `Rev_tick`.
- `Clear` (any state):
  - Sets `Fault`, `Err_count`, `Rev_count` and `good_cnt` to 0.
  - FAULT goes to SYNC. LOCKED stays LOCKED.
  - `Clear` takes priority over a same-edge bad step: no fault, no increment.
  - `Clear` in the same cycle as a revolution: `Rev_count` becomes 0 and `Rev_tick` is still asserted.
- `Count_in` is all-zero or multi-hot:
  - In LOCKED, it is a bad step.
  - On the following edge it is the `prev_q`, so that step is also bad. This keeps SYNC from locking until two clean samples have been seen.

## Timing
- All outputs are registered. Each output changes only on the rising edge of `Clock` or on the assertion of `Reset_n`.
- Reset (`Reset_n` = 0, asynchronous):
  - state = SYNC; `prev_v`, `prev_q` = 0.
  - `Phase_idx`, `Phase_valid`, `Rev_tick`, `Rev_count`, `Fault`, `Err_count` = 0.
- First edge after reset release: takes a sample only, with no check.
- Lock latency: `Phase_valid` rises at the edge where the LOCK_CNT-th consecutive good step is sampled. With the defaults this is the 3rd edge after release.
- `Phase_idx` reflects `Count_in` sampled at the same edge, so it lags the ring counter by one cycle.
- Fault latency: `Fault` rises and `Phase_valid` falls at the edge that samples the bad step.
- `Rev_tick` is high for exactly the one cycle following the edge that sampled the good step into phase 0.
- `Reset_n` asserted mid-operation: all state clears immediately. There is no partial count or fault retention.

## Test plan
- Lock from reset:
  - Stimulus: release `Reset_n`; drive 0001, 0010, 0100, 1000 on successive edges.
  - Required: `Phase_valid` = 1 after the 3rd edge, with `Phase_idx` = 2; `Phase_idx` = 3 on the next cycle; `Fault` = 0.
- Revolution count:
  - Stimulus: lock, then run 10 full revolutions.
  - Required: 10 `Rev_tick` pulses, each high for 1 cycle, coincident with `Phase_idx` = 0; `Rev_count` = 10.
- Wrap:
  - Stimulus: `REV_W` = 2, lock, then run 5 revolutions.
  - Required: `Rev_count` sequence 1, 2, 3, 0, 1.
- Illegal step:
  - Stimulus: locked at 0010, then drive 1000.
  - Required: next cycle `Fault` = 1, `Phase_valid` = 0, `Err_count` = 1; FAULT holds under further legal input.
- Clear behaviour:
  - Stimulus: from FAULT, pulse `Clear`; then drive 0001→0010→0100.
  - Required: `Fault` = 0 and `Err_count` = 0 after `Clear`; relock after the 2 good steps.
  - Stimulus: `Clear` on the same edge as a bad step while LOCKED.
  - Required: no fault and `Err_count` stays 0.
- Async reset mid-run and multi-hot input:
  - Stimulus: drop `Reset_n` between edges while locked.
  - Required: all outputs 0 immediately, without waiting for a clock edge.
  - Stimulus: in SYNC, drive 0011 then 0100, 1000, 0001.
  - Required: lock only after the good steps 0100→1000 and 1000→0001, i.e. after the 1000→0001 edge.
